result_deskew_writer: RTL

- Downstream neighbour of the 32x32 systolic array in TOP_tpu.
- Consumes the diagonally skewed partial-sum outputs from the bottom of the PE columns and realigns them into full result rows.
- Writes each realigned row into the result SRAM at consecutive addresses.
- Raises end_ when all MATRIX_SIZE rows are stored; the bench and controller then read results back.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/result_deskew_writer_if.sv | 34 +++
 rtl/col_delay_line.sv | 46 ++++
 rtl/result_deskew_writer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU types: array geometry defaults, the signed partial-sum lane type
// and the result deskew writer state encoding.
package tpu_pkg;

   localparam int DEF_MATRIX_SIZE    = 32;
   localparam int DEF_PARTIAL_SUM_BW = 24;

   typedef logic signed [DEF_PARTIAL_SUM_BW-1:0] psum_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/result_deskew_writer_if.sv
// Bundle between the systolic array bottom edge, the result SRAM write port and
// the tile controller; master drives start/psum, slave is the deskew writer.
interface result_deskew_writer_if #(
   parameter int MATRIX_SIZE    = 32,
   parameter int PARTIAL_SUM_BW = 24,
   parameter int ADDRESSSIZE    = 10
) ();
   import tpu_pkg::*;

   // No backpressure anywhere: psum_valid[c] qualifies column c of psum_in in
   // the cycle it is high, and sram_we qualifies sram_addr/sram_wdata; the SRAM
   // accepts every write, so there is no ready signal on either side.
   logic                                  start;
   logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] psum_in;
   logic [MATRIX_SIZE-1:0]                psum_valid;
   logic                                  sram_we;
   logic [ADDRESSSIZE-1:0]                sram_addr;
   logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] sram_wdata;
   logic                                  busy;
   logic                                  end_;
   logic                                  align_err;
   state_t                                dbg_state;

   modport master (
      output start, psum_in, psum_valid,
      input  sram_we, sram_addr, sram_wdata, busy, end_, align_err, dbg_state
   );

   modport slave (
      input  start, psum_in, psum_valid,
      output sram_we, sram_addr, sram_wdata, busy, end_, align_err, dbg_state
   );

endinterface

// File: rtl/col_delay_line.sv
// Fixed-depth {valid, data} shift register for one array column; depth 0 is a
// plain wire. Cleared asynchronously by rst and synchronously by flush.
module col_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, flush};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
   end else begin : g_shift
      logic [DEPTH-1:0] v_q;
      logic [W-1:0]     d_q [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
         end else if (flush) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
         end else begin
            v_q[0] <= in_valid;
            d_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
               v_q[i] <= v_q[i-1];
               d_q[i] <= d_q[i-1];
            end
         end
      end

      assign out_valid = v_q[DEPTH-1];
      assign out_data  = d_q[DEPTH-1];
   end

endmodule

// File: rtl/result_deskew_writer.sv
// Realigns diagonally skewed column partial sums into rows and writes them to
// the result SRAM. Optional RESULT_RELU_EN clamps negative lanes to 0 on write.
module result_deskew_writer
   import tpu_pkg::*;
#(
   parameter int MATRIX_SIZE      = DEF_MATRIX_SIZE,
   parameter int PARTIAL_SUM_BW   = DEF_PARTIAL_SUM_BW,
   parameter int ADDRESSSIZE      = 10,
   parameter int RESULT_BASE_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   result_deskew_writer_if.slave bus
);

   localparam int PSB = PARTIAL_SUM_BW;
   localparam int DW  = MATRIX_SIZE * PSB;

   state_t                 state, state_nxt;
   logic [MATRIX_SIZE-1:0] in_valid;
   logic [MATRIX_SIZE-1:0] al_valid;
   logic [DW-1:0]          al_data;
   logic [DW-1:0]          wr_data;
   logic                   all_valid, any_valid, last_row;
   logic                   do_write, err_set;
   logic [ADDRESSSIZE-1:0] row_cnt;
   logic                   we_q, err_q;
   logic [ADDRESSSIZE-1:0] addr_q;
   logic [DW-1:0]          wdata_q;

   // Nothing enters the delay lines while idle; DONE still listens so that
   // surplus rows can be flagged.
   assign in_valid = (state == IDLE) ? '0 : bus.psum_valid;

   for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
      col_delay_line #(
         .DEPTH (MATRIX_SIZE - 1 - c),
         .W     (PSB)
      ) u_delay (
         .clk       (clk),
         .rst       (rst),
         .flush     (bus.start),
         .in_valid  (in_valid[c]),
         .in_data   (bus.psum_in[c*PSB +: PSB]),
         .out_valid (al_valid[c]),
         .out_data  (al_data[c*PSB +: PSB])
      );
   end

   assign all_valid = &al_valid;
   assign any_valid = |al_valid;
   assign last_row  = (row_cnt == ADDRESSSIZE'(MATRIX_SIZE - 1));

   // start overrides everything, including the undelayed last column whose
   // input in the start cycle must be discarded like the rest.
   always_comb begin
      state_nxt = state;
      do_write  = 1'b0;
      err_set   = 1'b0;
      if (bus.start) begin
         state_nxt = COLLECT;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = IDLE;
            end
            COLLECT: begin
               if (all_valid) begin
                  do_write = 1'b1;
                  if (last_row) state_nxt = DONE;
               end else if (any_valid) begin
                  err_set = 1'b1;
               end
            end
            DONE: begin
               err_set = any_valid;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      wr_data = al_data;
`ifdef RESULT_RELU_EN
      for (int c = 0; c < MATRIX_SIZE; c++) begin
         if (al_data[c*PSB + PSB - 1]) wr_data[c*PSB +: PSB] = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else if (bus.start) begin
         row_cnt <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q <= do_write;
         if (do_write) begin
            addr_q  <= ADDRESSSIZE'(RESULT_BASE_ADDR) + row_cnt;
            wdata_q <= wr_data;
            row_cnt <= row_cnt + ADDRESSSIZE'(1);
         end
         if (err_set) err_q <= 1'b1;
      end
   end

   assign bus.sram_we    = we_q;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_wdata = wdata_q;
   assign bus.align_err  = err_q;
   assign bus.busy       = (state == COLLECT);
   assign bus.end_       = (state == DONE);
   assign bus.dbg_state  = state;

endmodule
